// File: rtl/imem_responder.sv
// Multicycle memory responder: one read/write request at a time over valid/ready,
// committed to a 16-bit word array after LATENCY edges, answered with a one-cycle pulse.
module imem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        err
);
    // state | meaning
    // IDLE  | no request in flight, ready to accept
    // WAIT  | request latched, counting down latency
    // DONE  | response cycle, may accept the next request
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam bit SINGLE = (LATENCY == 1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  hold_wr;
    logic [DEPTH_LOG2:0]   hold_addr;
    logic [15:0]           hold_wdata;
    logic [15:0]           mem [DEPTH];

    logic                  accept;
    logic                  commit;
    logic                  c_wr;
    logic [DEPTH_LOG2:0]   c_addr;
    logic [15:0]           c_wdata;
    logic [DEPTH_LOG2-1:0] c_idx;
    logic                  c_unaligned;
    logic                  unused_addr_bits;

    assign unused_addr_bits = &{1'b0, req_addr[15:DEPTH_LOG2+1]};

    assign req_ready = (state != WAIT);
    assign accept    = req_valid & req_ready;

    // With a single-cycle latency the access commits on the accept edge itself,
    // so the live request fields are used instead of the latched copy.
    always_comb begin
        c_wr    = hold_wr;
        c_addr  = hold_addr;
        c_wdata = hold_wdata;
        commit  = (state == WAIT) && (cnt == CNT_W'(1));
        if (SINGLE) begin
            c_wr    = req_wr;
            c_addr  = req_addr[DEPTH_LOG2:0];
            c_wdata = req_wdata;
            commit  = accept;
        end
    end

    assign c_idx       = c_addr[DEPTH_LOG2:1];
    assign c_unaligned = c_addr[0];

    // Array is deliberately outside reset; an aborted write never reaches it.
    always_ff @(posedge clk) begin
        if (!rst && commit && c_wr && !c_unaligned) begin
            mem[c_idx] <= c_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            err       <= 1'b0;

            if (accept) begin
                hold_wr    <= req_wr;
                hold_addr  <= req_addr[DEPTH_LOG2:0];
                hold_wdata <= req_wdata;
                cnt        <= CNT_LOAD;
                state      <= SINGLE ? DONE : WAIT;
            end else begin
                case (state)
                    WAIT: begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end

            if (commit) begin
                rsp_valid <= 1'b1;
                err       <= c_unaligned;
                rsp_rdata <= (!c_wr && !c_unaligned) ? mem[c_idx] : 16'h0000;
            end
        end
    end
endmodule
